// File: rtl/unidad_ejecucion_16bit.sv
// unidad_ejecucion_16bit: execute stage with single-cycle ALU ops and a 16-cycle shift-add multiply feeding the register bank write port
module unidad_ejecucion_16bit #(
    parameter int ANCHO    = 16,
    parameter int BITS_DIR = 3
) (
    input  logic                Reloj,
    input  logic                Reiniciar_n,
    input  logic                Valido,
    output logic                Listo,
    input  logic [2:0]          Operacion,
    input  logic [ANCHO-1:0]    RtaA,
    input  logic [ANCHO-1:0]    RtaB,
    input  logic [BITS_DIR-1:0] DireccionDestino,
    output logic [ANCHO-1:0]    Tupla,
    output logic                Habilitar,
    output logic [BITS_DIR-1:0] DireccionEscritura,
    output logic [3:0]          Banderas
);
    localparam int BITS_CNT = $clog2(ANCHO);
    typedef enum logic {REPOSO, MULTIPLICANDO} estado_t;
    estado_t estado, estado_sig;
    logic [2*ANCHO-1:0]  acumulador, multiplicando, acumulador_sig;
    logic [ANCHO-1:0]    multiplicador, resultado, producto;
    logic [BITS_CNT-1:0] contador, desplazamiento;
    logic [BITS_DIR-1:0] dir_mul;
    logic [ANCHO:0]      suma, resta, izq, der;
    logic                aceptar, fin_mul, acarreo, desborde;
    assign Listo = estado == REPOSO;
    always_comb begin
        desplazamiento = RtaB[BITS_CNT-1:0];
        suma = {1'b0, RtaA} + {1'b0, RtaB};
        resta = {1'b0, RtaA} - {1'b0, RtaB};
        izq = {1'b0, RtaA} << desplazamiento;
        der = {RtaA, 1'b0} >> desplazamiento;
        resultado = '0;
        acarreo = 1'b0;
        desborde = 1'b0;
        case (Operacion)
            3'b000: begin
                resultado = suma[ANCHO-1:0];
                acarreo = suma[ANCHO];
                desborde = (RtaA[ANCHO-1] == RtaB[ANCHO-1]) && (resultado[ANCHO-1] != RtaA[ANCHO-1]);
            end
            3'b001: begin
                resultado = resta[ANCHO-1:0];
                acarreo = resta[ANCHO];
                desborde = (RtaA[ANCHO-1] != RtaB[ANCHO-1]) && (resultado[ANCHO-1] != RtaA[ANCHO-1]);
            end
            3'b010: resultado = RtaA & RtaB;
            3'b011: resultado = RtaA | RtaB;
            3'b100: resultado = RtaA ^ RtaB;
            3'b101: {acarreo, resultado} = izq;
            3'b110: {resultado, acarreo} = der;
            default: resultado = '0;
        endcase
        acumulador_sig = acumulador + (multiplicador[0] ? multiplicando : '0);
        producto = acumulador_sig[ANCHO-1:0];
        aceptar = Valido && Listo;
        fin_mul = estado == MULTIPLICANDO && contador == BITS_CNT'(ANCHO - 1);
        estado_sig = estado;
        if (aceptar && Operacion == 3'b111)
            estado_sig = MULTIPLICANDO;
        else if (fin_mul)
            estado_sig = REPOSO;
    end
    always_ff @(posedge Reloj or negedge Reiniciar_n) begin
        if (!Reiniciar_n) begin
            estado <= REPOSO;
            Tupla <= '0;
            Habilitar <= 1'b0;
            DireccionEscritura <= '0;
            Banderas <= '0;
            acumulador <= '0;
            multiplicando <= '0;
            multiplicador <= '0;
            contador <= '0;
            dir_mul <= '0;
        end else begin
            estado <= estado_sig;
            Habilitar <= 1'b0;
            if (aceptar && Operacion == 3'b111) begin
                acumulador <= '0;
                multiplicando <= {{ANCHO{1'b0}}, RtaA};
                multiplicador <= RtaB;
                contador <= '0;
                dir_mul <= DireccionDestino;
            end else if (aceptar) begin
                Tupla <= resultado;
                Banderas <= {resultado == '0, resultado[ANCHO-1], acarreo, desborde};
                DireccionEscritura <= DireccionDestino;
                Habilitar <= 1'b1;
            end else if (estado == MULTIPLICANDO) begin
                acumulador <= acumulador_sig;
                multiplicando <= multiplicando << 1;
                multiplicador <= multiplicador >> 1;
                contador <= contador + 1'b1;
                if (fin_mul) begin
                    Tupla <= producto;
                    Banderas <= {producto == '0, producto[ANCHO-1], |acumulador_sig[2*ANCHO-1:ANCHO], 1'b0};
                    DireccionEscritura <= dir_mul;
                    Habilitar <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_unidad_ejecucion_16bit.sv
// tb_unidad_ejecucion_16bit: directed and randomized checks of the execute stage against an arithmetic reference model
module tb_unidad_ejecucion_16bit;
    logic        Reloj = 1'b0;
    logic        Reiniciar_n = 1'b0;
    logic        Valido = 1'b0;
    logic        Listo;
    logic [2:0]  Operacion = '0;
    logic [15:0] RtaA = '0;
    logic [15:0] RtaB = '0;
    logic [2:0]  DireccionDestino = '0;
    logic [15:0] Tupla;
    logic        Habilitar;
    logic [2:0]  DireccionEscritura;
    logic [3:0]  Banderas;
    int checks = 0;
    int errors = 0;

    unidad_ejecucion_16bit dut (
        .Reloj(Reloj), .Reiniciar_n(Reiniciar_n), .Valido(Valido), .Listo(Listo),
        .Operacion(Operacion), .RtaA(RtaA), .RtaB(RtaB), .DireccionDestino(DireccionDestino),
        .Tupla(Tupla), .Habilitar(Habilitar), .DireccionEscritura(DireccionEscritura), .Banderas(Banderas)
    );

    always #5 Reloj = ~Reloj;

    // Returns {Z,N,C,V,result} computed with plain integer arithmetic
    function automatic logic [19:0] modelo(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint r = 0;
        longint sr = 0;
        int sh = int'(b[3:0]);
        logic c = 1'b0;
        logic v = 1'b0;
        logic [15:0] res;
        case (op)
            3'd0: begin r = ua + ub; c = r > 65535; sr = sa + sb; v = sr > 32767 || sr < -32768; end
            3'd1: begin r = ua - ub; c = ua < ub; sr = sa - sb; v = sr > 32767 || sr < -32768; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << sh; c = sh != 0 && ((ua >> (16 - sh)) & 1) == 1; end
            3'd6: begin r = ua >> sh; c = sh != 0 && ((ua >> (sh - 1)) & 1) == 1; end
            default: begin r = ua * ub; c = r > 65535; end
        endcase
        res = r[15:0];
        return {res == 16'h0, res[15], c, v, res};
    endfunction

    // Issues one op at posedge+1 and reports edges-after-acceptance until Habilitar (-1 on timeout)
    task automatic exec_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] d, output int lat, output int busy);
        Operacion = op; RtaA = a; RtaB = b; DireccionDestino = d; Valido = 1'b1;
        @(posedge Reloj); #1;
        Valido = 1'b0;
        lat = 0;
        busy = Listo ? 0 : 1;
        while (Habilitar !== 1'b1 && lat < 40) begin
            RtaA = 16'($urandom); RtaB = 16'($urandom); Operacion = 3'($urandom);
            DireccionDestino = 3'($urandom); Valido = 1'($urandom);
            @(posedge Reloj); #1;
            lat++;
            if (!Listo) busy++;
        end
        Valido = 1'b0;
        if (Habilitar !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (Listo !== 1'b1) begin errors++; $display("FAIL reset_listo got %b want 1", Listo); end
        checks++; if (Habilitar !== 1'b0) begin errors++; $display("FAIL reset_hab got %b want 0", Habilitar); end
        checks++; if (Tupla !== 16'h0 || Banderas !== 4'h0 || DireccionEscritura !== 3'd0) begin
            errors++; $display("FAIL reset_outs got %h/%b/%0d want 0/0/0", Tupla, Banderas, DireccionEscritura); end
        repeat (2) @(negedge Reloj);
        Reiniciar_n = 1'b1;
        @(posedge Reloj); #1;
        checks++; if (Habilitar !== 1'b0 || Listo !== 1'b1) begin
            errors++; $display("FAIL post_reset got hab=%b listo=%b want 0/1", Habilitar, Listo); end
    endtask

    task automatic test_add;
        int lat, busy;
        exec_op(3'd0, 16'h7FFF, 16'h0001, 3'd3, lat, busy);
        checks++; if (lat !== 0) begin errors++; $display("FAIL add_lat got %0d want 0", lat); end
        checks++; if (Tupla !== 16'h8000 || DireccionEscritura !== 3'd3) begin
            errors++; $display("FAIL add_res got %h@%0d want 8000@3", Tupla, DireccionEscritura); end
        checks++; if (Banderas !== 4'b0101) begin errors++; $display("FAIL add_flags got %b want 0101", Banderas); end
        @(posedge Reloj); #1;
        checks++; if (Habilitar !== 1'b0) begin errors++; $display("FAIL add_pulse_len got %b want 0", Habilitar); end
        checks++; if (Tupla !== 16'h8000 || Banderas !== 4'b0101) begin
            errors++; $display("FAIL add_hold got %h/%b want 8000/0101", Tupla, Banderas); end
    endtask

    task automatic test_sub;
        int lat, busy;
        exec_op(3'd1, 16'h0005, 16'h0005, 3'd5, lat, busy);
        checks++; if (lat !== 0 || Tupla !== 16'h0000 || Banderas !== 4'b1000) begin
            errors++; $display("FAIL sub_zero got lat=%0d %h/%b want 0 0000/1000", lat, Tupla, Banderas); end
        exec_op(3'd1, 16'h0003, 16'h0005, 3'd0, lat, busy);
        checks++; if (lat !== 0 || Tupla !== 16'hFFFE || Banderas !== 4'b0110 || DireccionEscritura !== 3'd0) begin
            errors++; $display("FAIL sub_borrow got lat=%0d %h/%b@%0d want 0 FFFE/0110@0", lat, Tupla, Banderas, DireccionEscritura); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd4};
        logic [2:0]  dst [3] = '{3'd1, 3'd2, 3'd4};
        logic [15:0] exp [3] = '{16'h3030, 16'hFCFC, 16'hCCCC};
        RtaA = 16'hF0F0; RtaB = 16'h3C3C; Valido = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Operacion = ops[i]; DireccionDestino = dst[i];
            @(posedge Reloj); #1;
            checks++; if (Habilitar !== 1'b1 || Tupla !== exp[i] || DireccionEscritura !== dst[i] || Listo !== 1'b1) begin
                errors++; $display("FAIL b2b_%0d got hab=%b %h@%0d listo=%b want 1 %h@%0d 1",
                                   i, Habilitar, Tupla, DireccionEscritura, Listo, exp[i], dst[i]); end
        end
        Valido = 1'b0;
        @(posedge Reloj); #1;
        checks++; if (Habilitar !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", Habilitar); end
    endtask

    task automatic test_mul;
        int lat, busy;
        exec_op(3'd7, 16'h0123, 16'h0045, 3'd6, lat, busy);
        checks++; if (lat !== 16 || busy !== 16) begin
            errors++; $display("FAIL mul_timing got lat=%0d busy=%0d want 16/16", lat, busy); end
        checks++; if (Tupla !== 16'h4E6F || Banderas !== 4'b0000 || DireccionEscritura !== 3'd6) begin
            errors++; $display("FAIL mul_res got %h/%b@%0d want 4E6F/0000@6", Tupla, Banderas, DireccionEscritura); end
        checks++; if (Listo !== 1'b1) begin errors++; $display("FAIL mul_listo got %b want 1", Listo); end
        @(posedge Reloj); #1;
        checks++; if (Habilitar !== 1'b0) begin errors++; $display("FAIL mul_pulse_len got %b want 0", Habilitar); end
        exec_op(3'd7, 16'h1000, 16'h0010, 3'd7, lat, busy);
        checks++; if (lat !== 16 || Tupla !== 16'h0000 || Banderas !== 4'b1010) begin
            errors++; $display("FAIL mul_ovf got lat=%0d %h/%b want 16 0000/1010", lat, Tupla, Banderas); end
    endtask

    task automatic test_shift;
        int lat, busy;
        exec_op(3'd5, 16'h8001, 16'h0001, 3'd1, lat, busy);
        checks++; if (lat !== 0 || Tupla !== 16'h0002 || Banderas !== 4'b0010) begin
            errors++; $display("FAIL shl got lat=%0d %h/%b want 0 0002/0010", lat, Tupla, Banderas); end
        exec_op(3'd6, 16'h8001, 16'h0010, 3'd2, lat, busy);
        checks++; if (lat !== 0 || Tupla !== 16'h8001 || Banderas !== 4'b0100) begin
            errors++; $display("FAIL shr0 got lat=%0d %h/%b want 0 8001/0100", lat, Tupla, Banderas); end
    endtask

    task automatic test_mul_reset;
        int lat, busy, seen;
        Operacion = 3'd7; RtaA = 16'h00FF; RtaB = 16'h0101; DireccionDestino = 3'd5; Valido = 1'b1;
        @(posedge Reloj); #1;
        Valido = 1'b0;
        repeat (8) @(posedge Reloj);
        #2;
        checks++; if (Listo !== 1'b0) begin errors++; $display("FAIL abort_busy got listo=%b want 0", Listo); end
        Reiniciar_n = 1'b0;
        #1;
        checks++; if (Tupla !== 16'h0 || Banderas !== 4'h0 || Listo !== 1'b1 || Habilitar !== 1'b0 || DireccionEscritura !== 3'd0) begin
            errors++; $display("FAIL abort_outs got %h/%b listo=%b hab=%b@%0d want 0/0 1 0@0",
                               Tupla, Banderas, Listo, Habilitar, DireccionEscritura); end
        repeat (2) @(negedge Reloj);
        Reiniciar_n = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge Reloj); #1; if (Habilitar === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_pulse got %0d pulses want 0", seen); end
        exec_op(3'd0, 16'h0002, 16'h0003, 3'd4, lat, busy);
        checks++; if (lat !== 0 || Tupla !== 16'h0005 || Banderas !== 4'b0000 || DireccionEscritura !== 3'd4) begin
            errors++; $display("FAIL abort_add got lat=%0d %h/%b@%0d want 0 0005/0000@4", lat, Tupla, Banderas, DireccionEscritura); end
    endtask

    task automatic test_random;
        int lat, busy;
        logic [2:0]  op, d;
        logic [15:0] a, b;
        logic [19:0] exp;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom); d = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
            if (i % 5 == 0) a = 16'h8000 | 16'($urandom_range(0, 3));
            exp = modelo(op, a, b);
            exec_op(op, a, b, d, lat, busy);
            checks++; if (lat !== (op == 3'd7 ? 16 : 0) || Tupla !== exp[15:0] || Banderas !== exp[19:16] || DireccionEscritura !== d) begin
                errors++; $display("FAIL rand_%0d op=%0d a=%h b=%h got lat=%0d %h/%b@%0d want %0d %h/%b@%0d",
                                   i, op, a, b, lat, Tupla, Banderas, DireccionEscritura,
                                   op == 3'd7 ? 16 : 0, exp[15:0], exp[19:16], d); end
            if (($urandom & 1) == 1) begin @(posedge Reloj); #1; end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_back_to_back;
        test_mul;
        test_shift;
        test_mul_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidad_ejecucion_16bit.md
Name: unidad_ejecucion_16bit

Overview:
Execute stage directly downstream of Banco8Registros16Bit.
- Consumes the two read-port operands (RtaA, RtaB), a 3-bit operation code and a destination address.
- Computes the result: single-cycle ALU ops, plus a 16-cycle shift-add multiply.
- Drives the bank's write port (Tupla, Habilitar, DireccionEscritura) with the result, together with status flags.

Parameters:
ANCHO, 16, datapath width (operands, result); design is verified only at 16.
BITS_DIR, 3, register address width (8 registers).

Ports:
Reloj  input  1  clock; all state updates on rising edge.
Reiniciar_n  input  1  asynchronous, active-low reset.
Valido  input  1  upstream presents a valid operation this cycle.
Listo  output  1  stage can accept an operation; high exactly when FSM is in REPOSO.
Operacion  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
RtaA  input  ANCHO  operand A from bank read port A.
RtaB  input  ANCHO  operand B from bank read port B (shift amount = RtaB[3:0]).
DireccionDestino  input  BITS_DIR  destination register of the result.
Tupla  output  ANCHO  result, to bank write data.
Habilitar  output  1  one-cycle write-enable pulse to bank.
DireccionEscritura  output  BITS_DIR  write address to bank.
Banderas  output  4  {Z,N,C,V} of the last written result.

Behaviour:
- Reset (Reiniciar_n low, asynchronous, any time): FSM to REPOSO.
  - Tupla=0, Habilitar=0, DireccionEscritura=0, Banderas=0.
  - Multiply accumulator, multiplier and iteration counter cleared.
  - Listo=1 while in REPOSO, including during reset.
- Acceptance: an operation is taken at a rising edge where Valido=1 and Listo=1.
  - Operation, operands and destination are latched at acceptance; later input changes have no effect on it.
  - Valido while Listo=0 is ignored (not queued); upstream holds Valido until it sees Listo=1.
- FSM: REPOSO, MULTIPLICANDO.
  - REPOSO, accept of ops 000-110: result, address and flags registered on the same edge. Habilitar=1 for exactly the following cycle. Stay in REPOSO, so throughput is one op per cycle and back-to-back accepts give consecutive Habilitar pulses.
  - REPOSO, accept of op 111: go to MULTIPLICANDO with counter=0. Listo drops after that edge.
  - MULTIPLICANDO: one multiplier bit (LSB first) processed per edge. Add the shifted multiplicand to a 32-bit accumulator when the bit is 1.
    - On the 16th edge after acceptance, the low 16 bits go to Tupla, Habilitar=1 for the next cycle, and the FSM returns to REPOSO.
    - A new operation can be accepted on the 17th edge after acceptance.
  - Habilitar is 0 in every cycle not listed above.
- Arithmetic, all results truncated to 16 bits:
  - ADD: C = carry out; V = signed overflow.
  - SUB: A-B; C = borrow (1 when A<B unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: shift amount 0..15; C = last bit shifted out (0 for amount 0); V=0.
  - MUL: low 16 bits of the unsigned 32-bit product; C=1 when the upper 16 bits are nonzero; V=0.
  - All ops: Z = (result==0); N = result[15].
- Banderas and Tupla update only together with a Habilitar pulse and hold between pulses.
- Any destination 0..7 is written; there is no hard-wired zero register.
- Reset during MULTIPLICANDO aborts the multiply: no Habilitar pulse, outputs go to reset values.

Test Plan:
1. Reset, then ADD A=0x7FFF B=0x0001 dest=3 → next cycle Tupla=0x8000, Habilitar=1 for one cycle, DireccionEscritura=3, Banderas Z=0 N=1 C=0 V=1.
2. SUB 0x0005-0x0005 → Tupla=0x0000, Z=1 C=0. Then SUB 0x0003-0x0005 → Tupla=0xFFFE, N=1 C=1 V=0.
3. Back-to-back AND/OR/XOR on A=0xF0F0 B=0x3C3C, dests 1, 2, 4 on consecutive edges:
   - Three consecutive Habilitar pulses with Tupla 0x3030, 0xFCFC, 0xCCCC.
   - DireccionEscritura 1, 2, 4.
   - Listo stays 1 throughout.
4. MUL 0x0123×0x0045 dest=6:
   - Listo=0 for 16 cycles; inputs changed mid-op have no effect.
   - Habilitar pulses after the 16th edge with Tupla=0x4E6F, C=0.
   - Then MUL 0x1000×0x0010 → Tupla=0x0000, Z=1, C=1.
5. SHL 0x8001 by RtaB=0x0001 → Tupla=0x0002, C=1. SHR 0x8001 by RtaB=0x0010 (amount 0) → Tupla=0x8001, C=0, N=1.
6. Start MUL, pull Reiniciar_n low after the 8th edge:
   - Immediately Tupla=0, Banderas=0, Listo=1.
   - No Habilitar pulse ever appears.
   - After release, an ADD 0x0002+0x0003 completes normally with Tupla=0x0005.
